uriscv_axi_bridge: RTL and testbench
====================================

URISCV_AXI_BRIDGE -- requirements
Module: uriscv_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI and request address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 32 or 64; STRB_W = DATA_W/8 derived.
REQ-003 SHALL have ports: clk input 1, clock; rst_n input 1, reset, asynchronous active-low.
REQ-004 SHALL have fetch port: i_rd_i in 1, read request; i_addr_i in ADDR_W, address; i_accept_o out 1, request taken; i_valid_o out 1, data valid; i_rdata_o out DATA_W, read data.
REQ-005 SHALL have data port: d_rd_i in 1, read request; d_wr_i in STRB_W, write byte strobes; d_addr_i in ADDR_W, address; d_wdata_i in DATA_W, write data; d_accept_o out 1, request taken; d_ack_o out 1, completion; d_rdata_o out DATA_W, read data.
REQ-006 SHALL have AXI master ports aw{addr,len[3:0],size[2:0],burst[1:0],valid,ready}, w{data,strb,last,valid,ready}, b{resp[1:0],valid,ready}, ar{addr,len,size,burst,valid,ready}, r{data,last,resp,valid,ready}.
REQ-007 SHALL have err_o out 1, sticky bus error; err_addr_o out ADDR_W, faulting address; err_clr_i in 1, clears error.

Function
REQ-008 SHALL issue single-beat transactions only: awlen=arlen=0, awburst=arburst=INCR (2'b01), wlast=1.
REQ-009 SHALL use FSM states IDLE, WR (AW and W driven concurrently, each dropped independently after its handshake), WR_RESP, RD_ADDR, RD_DATA.
REQ-010 IDLE: on grant SHALL pulse the winner's accept for exactly one cycle, register address/data/strobes, move to WR (d_wr_i!=0) or RD_ADDR (read).
REQ-011 D request with both d_rd_i and nonzero d_wr_i SHALL be treated as a write.
REQ-012 Arbitration: when only one port requests it wins; when both request, round-robin, the port not granted last wins; after reset D has priority.
REQ-013 WR exits to WR_RESP only when both AW and W handshakes have completed, in any order or the same cycle.
REQ-014 bready and rready SHALL be high only in WR_RESP and RD_DATA respectively.
REQ-015 On B handshake: d_ack_o pulses one cycle, next cycle, FSM to IDLE.
REQ-016 On R handshake: rdata registered; the owner's i_valid_o or d_ack_o pulses the next cycle with data on *_rdata_o; FSM to IDLE.
REQ-017 Earliest next accept SHALL be the cycle of the ack/valid pulse (back-to-back latency: request to accept 1 cycle, accept to ack >=3 cycles).
REQ-018 awsize from strobes: all ones -> log2(STRB_W); two contiguous naturally aligned bytes -> 1; one byte -> 0; any other pattern -> log2(STRB_W); arsize always log2(STRB_W).
REQ-019 awaddr/araddr SHALL equal the registered request address unmodified; wstrb equals registered strobes.
REQ-020 AXI valids SHALL remain stable until handshake; payload SHALL not change while valid.

Reset
REQ-021 On rst_n low: FSM IDLE, all AXI valids/readies 0, accept/ack/valid outputs 0, rdata outputs 0, err_o 0, err_addr_o 0, arbiter last-grant = I.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no ack generated after release.

Configuration
REQ-023 Macro URISCV_AXI_BRIDGE_ERR_EN defined: bresp or rresp != OKAY sets err_o and captures err_addr_o (first error only until cleared); err_clr_i clears; simultaneous set and clear -> set wins; the transaction still completes normally.
REQ-024 Macro undefined: err_o and err_addr_o tied 0, err_clr_i ignored, ports retained.

Structure
REQ-025 Package uriscv_axi_pkg SHALL hold AXI resp constants (OKAY, EXOKAY, SLVERR, DECERR), burst constants, and the FSM state enum.
REQ-026 Arbitration SHALL be a sub-module uriscv_axi_rr_arb (two requesters, registered last-grant, update on accept).

Verification
REQ-027 D write 0x1000, strb 0xF, data 0xDEADBEEF; AW/W ready on same cycle; bresp OKAY -> awsize 2, d_ack_o one pulse, 3 cycles after accept.
REQ-028 Write strb 0xC to 0x2002; wready 4 cycles after awready -> awsize 1, WR_RESP entered only after W handshake.
REQ-029 I and D read together, repeated 4 times -> grants alternate D, I, D, I...; i_rdata_o/d_rdata_o match rdata.
REQ-030 Read 0x3000 with rresp SLVERR (ERR_EN defined) -> err_o=1, err_addr_o=0x3000, ack still pulses; err_clr_i -> err_o=0.
REQ-031 rst_n asserted while arvalid high and arready low -> arvalid 0 immediately, no ack/valid after release.
REQ-032 arvalid held 5 cycles with arready low -> araddr, arsize stable throughout.

Source files
------------

// File: rtl/uriscv_axi_pkg.sv
// Shared AXI constants, bridge FSM state type and the strobe-to-size helper for uriscv_axi_bridge.
package uriscv_axi_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData
  } state_e;

  // Strobes are zero-extended to 8 bits so one helper serves 32- and 64-bit buses.
  function automatic logic [2:0] size_from_strb(input logic [7:0] strb, input int unsigned strb_w);
    logic [2:0] full_size;
    logic [7:0] full_mask;
    full_size = (strb_w == 8) ? 3'd3 : 3'd2;
    full_mask = (strb_w == 8) ? 8'hff : 8'h0f;
    if (strb == full_mask) begin
      return full_size;
    end else if (strb != 8'h00 && (strb & (strb - 8'd1)) == 8'h00) begin
      return 3'd0;
    end else if (strb == 8'h03 || strb == 8'h0c || strb == 8'h30 || strb == 8'hc0) begin
      return 3'd1;
    end
    return full_size;
  endfunction

endpackage

// File: rtl/uriscv_axi_rr_arb.sv
// Two-requester round-robin arbiter; on a tie the port not granted last wins, D wins after reset.
module uriscv_axi_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic update_i,
  output logic i_gnt_o,
  output logic d_gnt_o
);

  logic last_d_q;

  assign d_gnt_o = d_req_i & (~i_req_i | ~last_d_q);
  assign i_gnt_o = i_req_i & ~d_gnt_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (update_i && (i_req_i || d_req_i)) begin
      last_d_q <= d_gnt_o;
    end
  end

endmodule

// File: rtl/uriscv_axi_bridge.sv
// Bridges the uriscv fetch and data ports onto a single-beat AXI master.
// Define URISCV_AXI_BRIDGE_ERR_EN to enable sticky bus-error capture on err_o/err_addr_o.
module uriscv_axi_bridge
  import uriscv_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_accept_o,
  output logic              i_valid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_rd_i,
  input  logic [STRB_W-1:0] d_wr_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_accept_o,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [3:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [3:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rlast_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o,
  input  logic              err_clr_i
);

  localparam logic [2:0] FullSize = (DATA_W == 64) ? 3'd3 : 3'd2;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              owner_d_q, aw_done_q, w_done_q;
  logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic              i_accept_q, d_accept_q, i_valid_q, d_ack_q;
  logic              i_gnt, d_gnt, d_req, idle;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [7:0]        strb8;

  assign d_req = d_rd_i | (|d_wr_i);
  assign idle  = (state_q == StIdle);
  assign aw_hs = awvalid_q & awready_i;
  assign w_hs  = wvalid_q & wready_i;
  assign b_hs  = bready_q & bvalid_i;
  assign ar_hs = arvalid_q & arready_i;
  assign r_hs  = rready_q & rvalid_i;

  uriscv_axi_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req_i  (i_rd_i),
    .d_req_i  (d_req),
    .update_i (idle),
    .i_gnt_o  (i_gnt),
    .d_gnt_o  (d_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      owner_d_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      i_accept_q <= 1'b0;
      d_accept_q <= 1'b0;
      i_valid_q  <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_accept_q <= 1'b0;
      d_accept_q <= 1'b0;
      i_valid_q  <= 1'b0;
      d_ack_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (d_gnt) begin
            d_accept_q <= 1'b1;
            owner_d_q  <= 1'b1;
            addr_q     <= d_addr_i;
            wdata_q    <= d_wdata_i;
            strb_q     <= d_wr_i;
            state_q    <= (|d_wr_i) ? StWr : StRdAddr;
          end else if (i_gnt) begin
            i_accept_q <= 1'b1;
            owner_d_q  <= 1'b0;
            addr_q     <= i_addr_i;
            strb_q     <= '0;
            state_q    <= StRdAddr;
          end
        end
        // AW and W are raised together on the first WR cycle and retire independently.
        StWr: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end else if (!aw_done_q) begin
            awvalid_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end else if (!w_done_q) begin
            wvalid_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= StWrResp;
          end
        end
        StWrResp: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            d_ack_q  <= 1'b1;
            state_q  <= StIdle;
          end
        end
        StRdAddr: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdData;
          end else begin
            arvalid_q <= 1'b1;
          end
        end
        StRdData: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            state_q  <= StIdle;
            if (owner_d_q) begin
              d_rdata_q <= rdata_i;
              d_ack_q   <= 1'b1;
            end else begin
              i_rdata_q <= rdata_i;
              i_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    strb8 = '0;
    strb8[STRB_W-1:0] = strb_q;
  end

  assign i_accept_o = i_accept_q;
  assign i_valid_o  = i_valid_q;
  assign i_rdata_o  = i_rdata_q;
  assign d_accept_o = d_accept_q;
  assign d_ack_o    = d_ack_q;
  assign d_rdata_o  = d_rdata_q;
  assign awaddr_o   = addr_q;
  assign awlen_o    = 4'd0;
  assign awsize_o   = size_from_strb(strb8, STRB_W);
  assign awburst_o  = BurstIncr;
  assign awvalid_o  = awvalid_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = strb_q;
  assign wlast_o    = 1'b1;
  assign wvalid_o   = wvalid_q;
  assign bready_o   = bready_q;
  assign araddr_o   = addr_q;
  assign arlen_o    = 4'd0;
  assign arsize_o   = FullSize;
  assign arburst_o  = BurstIncr;
  assign arvalid_o  = arvalid_q;
  assign rready_o   = rready_q;

`ifdef URISCV_AXI_BRIDGE_ERR_EN
  logic              err_q, err_set;
  logic [ADDR_W-1:0] err_addr_q;
  logic              unused_sig;

  assign err_set = (b_hs && bresp_i != RespOkay) || (r_hs && rresp_i != RespOkay);

  // Set beats clear so an error landing with err_clr_i is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (err_set) begin
      err_q <= 1'b1;
      if (!err_q) err_addr_q <= addr_q;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
  assign unused_sig = rlast_i;
`else
  logic unused_sig;
  assign err_o      = 1'b0;
  assign err_addr_o = '0;
  assign unused_sig = ^{rlast_i, bresp_i, rresp_i, err_clr_i};
`endif

endmodule

// File: tb/tb_uriscv_axi_bridge.sv
// Directed self-checking bench for uriscv_axi_bridge with hand-computed expectations.
module tb_uriscv_axi_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rd_i, i_accept_o, i_valid_o;
  logic [31:0] i_addr_i, i_rdata_o;
  logic        d_rd_i, d_accept_o, d_ack_o;
  logic [3:0]  d_wr_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i, err_addr_o;
  logic [3:0]  awlen_o, arlen_o, wstrb_o;
  logic [2:0]  awsize_o, arsize_o;
  logic [1:0]  awburst_o, arburst_o, bresp_i, rresp_i;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
  logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o, err_o, err_clr_i;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  uriscv_axi_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd_i(i_rd_i), .i_addr_i(i_addr_i), .i_accept_o(i_accept_o), .i_valid_o(i_valid_o),
    .i_rdata_o(i_rdata_o),
    .d_rd_i(d_rd_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_accept_o(d_accept_o), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rlast_i(rlast_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_rd_i = 0; i_addr_i = 0; d_rd_i = 0; d_wr_i = 0; d_addr_i = 0; d_wdata_i = 0;
    awready_i = 0; wready_i = 0; bresp_i = 0; bvalid_i = 0; arready_i = 0;
    rdata_i = 0; rlast_i = 0; rresp_i = 0; rvalid_i = 0; err_clr_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_accept(output bit gi, output bit gd);
    gi = 0; gd = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (i_accept_o || d_accept_o) begin
        gi = i_accept_o; gd = d_accept_o;
        break;
      end
    end
  endtask

  // Returns in the cycle where the owner's valid/ack is expected.
  task automatic serve_read(input logic [31:0] data, input logic [1:0] resp, output bit ok);
    ok = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (arvalid_o) break;
    end
    if (!arvalid_o) return;
    arready_i = 1; tick(); arready_i = 0;
    if (!rready_o) return;
    rvalid_i = 1; rdata_i = data; rresp_i = resp; rlast_i = 1;
    tick();
    rvalid_i = 0; rlast_i = 0; rresp_i = 0;
    ok = 1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] strb, input logic rd,
                          output logic [2:0] size, output bit ack);
    bit gi, gd;
    d_addr_i = addr; d_wdata_i = 32'h5555_aaaa; d_wr_i = strb; d_rd_i = rd;
    size = 3'h7; ack = 0;
    wait_accept(gi, gd);
    d_wr_i = 0; d_rd_i = 0;
    if (!gd) return;
    awready_i = 1; wready_i = 1;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (awvalid_o) begin size = awsize_o; break; end
    end
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bready_o) break;
    end
    awready_i = 0; wready_i = 0;
    if (!bready_o) return;
    bvalid_i = 1; bresp_i = 2'b00;
    tick();
    ack = d_ack_o; bvalid_i = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o} !== 5'b0) begin
      n_fails++; $display("FAIL reset_axi: got %b want 00000",
                          {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o});
    end
    n_checks++;
    if ({i_accept_o, i_valid_o, d_accept_o, d_ack_o, err_o} !== 5'b0) begin
      n_fails++; $display("FAIL reset_ctl: got %b want 00000",
                          {i_accept_o, i_valid_o, d_accept_o, d_ack_o, err_o});
    end
    n_checks++;
    if (i_rdata_o !== 0 || d_rdata_o !== 0 || err_addr_o !== 0) begin
      n_fails++; $display("FAIL reset_data: got %h %h %h want 0", i_rdata_o, d_rdata_o, err_addr_o);
    end
    apply_reset();
  endtask

  task automatic test_write_full();
    d_addr_i = 32'h1000; d_wdata_i = 32'hdead_beef; d_wr_i = 4'hf;
    tick();
    n_checks++;
    if (d_accept_o !== 1'b1) begin
      n_fails++; $display("FAIL wr_accept_latency: got %b want 1", d_accept_o);
    end
    d_wr_i = 0; awready_i = 1; wready_i = 1;
    tick();
    n_checks++;
    if (awvalid_o !== 1 || wvalid_o !== 1 || awaddr_o !== 32'h1000 || awsize_o !== 3'd2) begin
      n_fails++; $display("FAIL wr_aw: got v%b%b addr %h size %0d want v11 addr 1000 size 2",
                          awvalid_o, wvalid_o, awaddr_o, awsize_o);
    end
    n_checks++;
    if (wdata_o !== 32'hdead_beef || wstrb_o !== 4'hf || wlast_o !== 1 || awlen_o !== 0 ||
        awburst_o !== 2'b01) begin
      n_fails++; $display("FAIL wr_w: got %h %h last%b len%0d burst%0d want deadbeef f 1 0 1",
                          wdata_o, wstrb_o, wlast_o, awlen_o, awburst_o);
    end
    tick();
    n_checks++;
    if (bready_o !== 1 || awvalid_o !== 0 || wvalid_o !== 0) begin
      n_fails++; $display("FAIL wr_bready: got b%b aw%b w%b want 1 0 0", bready_o, awvalid_o, wvalid_o);
    end
    awready_i = 0; wready_i = 0; bvalid_i = 1; bresp_i = 2'b00;
    tick();
    bvalid_i = 0;
    n_checks++;
    if (d_ack_o !== 1 || bready_o !== 0) begin
      n_fails++; $display("FAIL wr_ack_3cyc: got ack%b bready%b want 1 0", d_ack_o, bready_o);
    end
    tick();
    n_checks++;
    if (d_ack_o !== 0) begin
      n_fails++; $display("FAIL wr_ack_pulse: got %b want 0", d_ack_o);
    end
  endtask

  task automatic test_write_half();
    bit gi, gd, early, wdrop;
    d_addr_i = 32'h2002; d_wdata_i = 32'h1234_0000; d_wr_i = 4'hc;
    wait_accept(gi, gd);
    d_wr_i = 0; awready_i = 1; wready_i = 0;
    n_checks++;
    if (gd !== 1) begin
      n_fails++; $display("FAIL half_accept: got %b want 1", gd);
    end
    tick();
    n_checks++;
    if (awvalid_o !== 1 || awsize_o !== 3'd1 || wstrb_o !== 4'hc || awaddr_o !== 32'h2002) begin
      n_fails++; $display("FAIL half_aw: got v%b size %0d strb %h addr %h want 1 1 c 2002",
                          awvalid_o, awsize_o, wstrb_o, awaddr_o);
    end
    early = 0; wdrop = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bready_o) early = 1;
      if (!wvalid_o) wdrop = 1;
    end
    n_checks++;
    if (early || wdrop || awvalid_o !== 0) begin
      n_fails++; $display("FAIL half_wait_w: got early%b wdrop%b aw%b want 0 0 0", early, wdrop, awvalid_o);
    end
    awready_i = 0; wready_i = 1;
    tick();
    wready_i = 0;
    n_checks++;
    if (bready_o !== 1 || wvalid_o !== 0) begin
      n_fails++; $display("FAIL half_wresp: got b%b w%b want 1 0", bready_o, wvalid_o);
    end
    bvalid_i = 1;
    tick();
    bvalid_i = 0;
    n_checks++;
    if (d_ack_o !== 1) begin
      n_fails++; $display("FAIL half_ack: got %b want 1", d_ack_o);
    end
    tick();
  endtask

  task automatic test_awsize();
    logic [3:0] strbs [5] = '{4'h1, 4'h3, 4'h6, 4'h8, 4'h5};
    logic       rds   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] sizes [5] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd2};
    logic [2:0] size;
    bit         ack;
    for (int k = 0; k < 5; k++) begin
      do_write(32'h0000_0400, strbs[k], rds[k], size, ack);
      n_checks++;
      if (size !== sizes[k] || ack !== 1) begin
        n_fails++; $display("FAIL awsize_%0d: strb %h got size %0d ack %b want size %0d ack 1",
                            k, strbs[k], size, ack, sizes[k]);
      end
    end
  endtask

  task automatic test_read_alternate();
    bit          gi, gd, ok, exp_d;
    logic [31:0] data;
    apply_reset();
    i_addr_i = 32'h0000_0100; d_addr_i = 32'h0000_8000;
    i_rd_i = 1; d_rd_i = 1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      data  = 32'ha5a5_0000 + k;
      wait_accept(gi, gd);
      n_checks++;
      if ({gi, gd} !== {!exp_d, exp_d}) begin
        n_fails++; $display("FAIL rr_grant_%0d: got i%b d%b want i%b d%b", k, gi, gd, !exp_d, exp_d);
      end
      if (gd) d_rd_i = 0; else i_rd_i = 0;
      serve_read(data, 2'b00, ok);
      n_checks++;
      if (exp_d ? (d_ack_o !== 1 || d_rdata_o !== data || i_valid_o !== 0)
                : (i_valid_o !== 1 || i_rdata_o !== data || d_ack_o !== 0) || !ok) begin
        n_fails++; $display("FAIL rr_data_%0d: got ok%b iv%b %h dack%b %h want data %h to %s",
                            k, ok, i_valid_o, i_rdata_o, d_ack_o, d_rdata_o, data, exp_d ? "D" : "I");
      end
      if (gd) d_rd_i = 1; else i_rd_i = 1;
    end
    i_rd_i = 0; d_rd_i = 0;
    tick(); tick();
  endtask

  task automatic test_read_err();
    bit gi, gd, ok;
    d_addr_i = 32'h3000; d_rd_i = 1;
    wait_accept(gi, gd);
    d_rd_i = 0;
    serve_read(32'h0bad_0bad, 2'b10, ok);
    n_checks++;
    if (!ok || !gd || d_ack_o !== 1 || d_rdata_o !== 32'h0bad_0bad) begin
      n_fails++; $display("FAIL err_ack: got ok%b gd%b ack%b %h want 1 1 1 0bad0bad",
                          ok, gd, d_ack_o, d_rdata_o);
    end
    tick();
    n_checks++;
`ifdef URISCV_AXI_BRIDGE_ERR_EN
    if (err_o !== 1 || err_addr_o !== 32'h3000) begin
      n_fails++; $display("FAIL err_set: got %b %h want 1 3000", err_o, err_addr_o);
    end
`else
    if (err_o !== 0 || err_addr_o !== 0) begin
      n_fails++; $display("FAIL err_tied: got %b %h want 0 0", err_o, err_addr_o);
    end
`endif
    err_clr_i = 1; tick(); err_clr_i = 0;
    n_checks++;
    if (err_o !== 0) begin
      n_fails++; $display("FAIL err_clr: got %b want 0", err_o);
    end
  endtask

  task automatic test_ar_stable();
    bit gi, gd, ok, bad;
    d_addr_i = 32'h6004; d_rd_i = 1;
    wait_accept(gi, gd);
    d_rd_i = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (arvalid_o) break;
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (arvalid_o !== 1 || araddr_o !== 32'h6004 || arsize_o !== 3'd2 || arlen_o !== 0 ||
          arburst_o !== 2'b01) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fails++; $display("FAIL ar_stable: got v%b %h size %0d want 1 6004 2", arvalid_o, araddr_o, arsize_o);
    end
    serve_read(32'h7777_0001, 2'b00, ok);
    n_checks++;
    if (!ok || d_ack_o !== 1 || d_rdata_o !== 32'h7777_0001) begin
      n_fails++; $display("FAIL ar_stable_data: got ok%b ack%b %h want 1 1 77770001", ok, d_ack_o, d_rdata_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit gi, gd, bad;
    d_addr_i = 32'h5000; d_rd_i = 1;
    wait_accept(gi, gd);
    d_rd_i = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (arvalid_o) break;
    end
    n_checks++;
    if (arvalid_o !== 1) begin
      n_fails++; $display("FAIL mid_arvalid: got %b want 1", arvalid_o);
    end
    rst_n = 0;
    #1;
    n_checks++;
    if (arvalid_o !== 0 || rready_o !== 0) begin
      n_fails++; $display("FAIL mid_async: got ar%b r%b want 0 0", arvalid_o, rready_o);
    end
    @(posedge clk); #1 rst_n = 1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_ack_o || i_valid_o || arvalid_o) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fails++; $display("FAIL mid_no_ack: got spurious ack/valid/arvalid after reset");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    apply_reset();
    test_reset();
    test_write_full();
    test_write_half();
    test_awsize();
    test_read_alternate();
    test_read_err();
    test_ar_stable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
